// File: rtl/main_stream_ctrl_pkg.sv
// Shared types and defaults for the kernel launch/sequencing controller.
// The credit width helper gives the smallest width able to hold MAX_INFLIGHT.
package main_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_CNTW         = 32;
    localparam int DEF_MAX_INFLIGHT = 16;

    function automatic int credit_width(input int max_inflight);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max_inflight) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/main_ctrl_credit_cnt.sv
// Up/down saturating credit counter: words accepted by the kernel but not yet emitted.
// Simultaneous inc and dec leave the count unchanged.
module main_ctrl_credit_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] limit,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] count_reg, count_next;

    assign full  = (count_reg >= limit);
    assign empty = (count_reg == '0);

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !dec && !full) begin
            count_next = count_reg + 1'b1;
        end else if (dec && !inc && !empty) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_reg <= '0;
        else     count_reg <= count_next;
    end

endmodule

// File: rtl/main_stream_ctrl.sv
// Launch/sequencing controller in front of the vectorised kernel top: gates the source stream,
// bounds in-flight words with credits, pulses done. Optional cycle counter: MAIN_STREAM_CTRL_PERF_CNT_EN.
module main_stream_ctrl
    import main_stream_ctrl_pkg::*;
#(
    parameter int CNTW         = DEF_CNTW,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int CRW          = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] num_words,
    output logic            busy,
    output logic            done,
    output logic            err,
    input  logic            src_valid,
    output logic            src_ready,
    output logic            k_ivalid,
    input  logic            k_iready,
    input  logic            k_ovalid,
    output logic            k_oready,
    output logic            snk_valid,
    input  logic            snk_ready,
    output logic [31:0]     cycle_count
);

    // Never narrower than MAX_INFLIGHT needs, even if CRW is misconfigured.
    localparam int CW = (CRW > credit_width(MAX_INFLIGHT)) ? CRW : credit_width(MAX_INFLIGHT);

    state_t          state_reg, state_next;
    logic [CNTW-1:0] tgt_reg, in_cnt_reg, out_cnt_reg;
    logic            err_reg;
    logic            credit_full, credit_empty;
    logic            accept_start, issue_ok, out_ok;
    logic            in_beat, out_beat, spur_beat, out_last;

    assign accept_start = (state_reg == IDLE) && start;
    assign issue_ok     = (state_reg == RUN) && (in_cnt_reg < tgt_reg) && !credit_full;
    assign out_ok       = (state_reg == RUN) || (state_reg == DRAIN);

    assign k_ivalid  = src_valid & issue_ok;
    assign src_ready = k_iready & issue_ok;
    assign in_beat   = src_valid & k_iready & issue_ok;

    // Kernel output with no outstanding credit is swallowed and flagged, never forwarded.
    assign snk_valid = k_ovalid & out_ok & !credit_empty;
    assign k_oready  = snk_ready & out_ok;
    assign out_beat  = k_ovalid & k_oready & !credit_empty;
    assign spur_beat = k_ovalid & k_oready & credit_empty;
    assign out_last  = out_beat && ((out_cnt_reg + CNTW'(1)) == tgt_reg);

    assign err = err_reg;

    main_ctrl_credit_cnt #(
        .W(CW)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_start),
        .inc   (in_beat),
        .dec   (out_beat),
        .limit (CW'(MAX_INFLIGHT)),
        .full  (credit_full),
        .empty (credit_empty)
    );

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = (num_words == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (out_last)                     state_next = DONE;
                else if (in_cnt_reg == tgt_reg)   state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            tgt_reg     <= '0;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_start) begin
                tgt_reg     <= num_words;
                in_cnt_reg  <= '0;
                out_cnt_reg <= '0;
                err_reg     <= 1'b0;
            end else begin
                if (in_beat)   in_cnt_reg  <= in_cnt_reg + 1'b1;
                if (out_beat)  out_cnt_reg <= out_cnt_reg + 1'b1;
                if (spur_beat) err_reg     <= 1'b1;
            end
        end
    end

`ifdef MAIN_STREAM_CTRL_PERF_CNT_EN
    logic [31:0] perf_reg;

    // Only advances in RUN/DRAIN, so the value holds from done until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              perf_reg <= '0;
        else if (accept_start)                perf_reg <= '0;
        else if (out_ok && (perf_reg != '1))  perf_reg <= perf_reg + 1'b1;
    end

    assign cycle_count = perf_reg;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_main_stream_ctrl.sv
// Self-checking bench for main_stream_ctrl: table-driven jobs against a latency-model kernel,
// plus hand sequences for zero-length jobs, spurious kernel output and mid-run reset.
module tb_main_stream_ctrl;

    localparam int MAXF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] num_words = '0;
    logic        busy, done, err;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic        k_ivalid;
    logic        k_iready = 1'b1;
    logic        k_ovalid = 1'b0;
    logic        k_oready;
    logic        snk_valid;
    logic        snk_ready = 1'b0;
    logic [31:0] cycle_count;

    main_stream_ctrl #(
        .CNTW         (32),
        .MAX_INFLIGHT (MAXF),
        .CRW          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_words   (num_words),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .k_ivalid    (k_ivalid),
        .k_iready    (k_iready),
        .k_ovalid    (k_ovalid),
        .k_oready    (k_oready),
        .snk_valid   (snk_valid),
        .snk_ready   (snk_ready),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int lat;
        int stall;
        int exp_in;
        int exp_out;
        int exp_stall_in;
        int exp_err;
    } vec_t;

    int tests = 0;
    int failed = 0;

    // Kernel model state and scoreboard
    int  cyc = 0;
    int  lat = 1;
    int  kq_rdy[$];
    int  sbq[$];
    bit  force_spur = 1'b0;
    bit  spur_now = 1'b0;
    int  cur_n = 0;
    int  in_beats, out_beats, done_pulses, done_cyc, exp_done_cyc, max_infl;
    int  ivalid_seen, busy_seen;
    longint cc_at_done;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats(input int n, input int l);
        in_beats = 0; out_beats = 0; done_pulses = 0; done_cyc = -2;
        exp_done_cyc = -1; max_infl = 0; ivalid_seen = 0; busy_seen = 0;
        cur_n = n; lat = l; cc_at_done = -1;
    endtask

    // Kernel: a word taken in cycle c is presented on k_ovalid from cycle c+lat+1.
    always @(posedge clk) begin
        #1;
        spur_now = force_spur;
        k_ovalid = !rst && (force_spur || (kq_rdy.size() > 0 && kq_rdy[0] <= cyc));
    end

    always @(negedge clk) begin
        bit ib, kp, sb;
        if (rst) begin
            kq_rdy.delete();
            sbq.delete();
        end else begin
            ib = k_ivalid && k_iready;
            kp = k_ovalid && k_oready && !spur_now;
            sb = snk_valid && snk_ready;
            if (k_ivalid) ivalid_seen++;
            if (busy) busy_seen++;
            if (done) begin
                done_pulses++;
                done_cyc = cyc;
                cc_at_done = cycle_count;
            end
            if (kp || sb) begin
                tests++;
                if (kp != sb) begin
                    failed++;
                    $display("FAIL fwd cyc=%0d: sink beat %0d kernel pop %0d", cyc, sb, kp);
                end
            end
            if (kp && kq_rdy.size() > 0) void'(kq_rdy.pop_front());
            if (sb) begin
                if (sbq.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL sink_extra cyc=%0d: sink beat with 0 expected pending, required none", cyc);
                end else begin
                    void'(sbq.pop_front());
                end
                out_beats++;
                if (out_beats == cur_n) exp_done_cyc = cyc + 1;
            end
            if (ib) begin
                kq_rdy.push_back(cyc + lat + 1);
                sbq.push_back(in_beats);
                in_beats++;
            end
            if (kq_rdy.size() > max_infl) max_infl = kq_rdy.size();
        end
        cyc++;
    end

    task automatic wait_done(input string tag);
        bit fin;
        int extra;
        fin = 0;
        extra = 0;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk); #1;
            if (done_pulses > 0) extra++;
            if (extra >= 3) fin = 1;
        end
        chk({tag, "_completes"}, fin, 1);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int  stall_left;
        int  extra;
        bit  fin;
        int  stall_in;
        bit  stall_srdy;
        stall_in = -1;
        stall_srdy = 1'b1;
        @(posedge clk); #2;
        clear_stats(v.n, v.lat);
        num_words = v.n;
        start = 1'b1;
        src_valid = 1'b1;
        k_iready = 1'b1;
        stall_left = v.stall;
        snk_ready = (stall_left == 0);
        @(posedge clk); #2;
        start = 1'b0;
        fin = 0;
        extra = 0;
        for (int c = 0; c < 500 && !fin; c++) begin
            @(negedge clk); #1;
            if (v.stall > 0 && stall_left == 1) begin
                stall_in = in_beats;
                stall_srdy = src_ready;
            end
            if (done_pulses > 0) extra++;
            if (extra >= 3) fin = 1;
            @(posedge clk); #2;
            if (stall_left > 0) stall_left--;
            snk_ready = (stall_left == 0);
        end
        src_valid = 1'b0;
        $display("[TB] job %s n=%0d lat=%0d stall=%0d in=%0d out=%0d done_at=%0d", tag, v.n, v.lat, v.stall,
                 in_beats, out_beats, done_cyc);
        chk({tag, "_completes"}, fin, 1);
        chk({tag, "_in_beats"}, in_beats, v.exp_in);
        chk({tag, "_out_beats"}, out_beats, v.exp_out);
        chk({tag, "_done_pulses"}, done_pulses, 1);
        chk({tag, "_done_cycle"}, done_cyc, exp_done_cyc);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_inflight_le_max"}, (max_infl <= MAXF), 1);
        chk({tag, "_pending_left"}, sbq.size(), 0);
        chk({tag, "_err"}, err, v.exp_err);
        if (v.stall > 0) begin
            chk({tag, "_stall_in_beats"}, stall_in, v.exp_stall_in);
            chk({tag, "_stall_src_ready"}, stall_srdy, 0);
        end
`ifndef MAIN_STREAM_CTRL_PERF_CNT_EN
        chk({tag, "_cycle_count_tied"}, cycle_count, 0);
`endif
    endtask

    vec_t vecs[6];
    vec_t v;
    int   s;

    initial begin
        vecs[0] = '{n:8,  lat:3, stall:0,  exp_in:8,  exp_out:8,  exp_stall_in:0, exp_err:0};
        vecs[1] = '{n:10, lat:1, stall:20, exp_in:10, exp_out:10, exp_stall_in:4, exp_err:0};
        vecs[2] = '{n:5,  lat:0, stall:0,  exp_in:5,  exp_out:5,  exp_stall_in:0, exp_err:0};
        vecs[3] = '{n:1,  lat:2, stall:0,  exp_in:1,  exp_out:1,  exp_stall_in:0, exp_err:0};
        vecs[4] = '{n:3,  lat:5, stall:7,  exp_in:3,  exp_out:3,  exp_stall_in:3, exp_err:0};
        vecs[5] = '{n:12, lat:0, stall:6,  exp_in:12, exp_out:12, exp_stall_in:4, exp_err:0};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        src_valid = 1'b1;
        snk_ready = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_k_ivalid", k_ivalid, 0);
        chk("rst_k_oready", k_oready, 0);
        chk("rst_snk_valid", snk_valid, 0);
        chk("rst_cycle_count", cycle_count, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        src_valid = 1'b0;
        @(negedge clk); #1;
        chk("idle_src_ready", src_ready, 0);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-length job goes straight to DONE
        @(posedge clk); #2;
        clear_stats(0, 1);
        num_words = 0;
        start = 1'b1;
        src_valid = 1'b1;
        snk_ready = 1'b1;
        s = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        src_valid = 1'b0;
        $display("[TB] job zero n=0 done_at=%0d start_at=%0d", done_cyc, s);
        chk("zero_done_pulses", done_pulses, 1);
        chk("zero_done_cycle", done_cyc, s + 1);
        chk("zero_no_ivalid", ivalid_seen, 0);
        chk("zero_no_busy", busy_seen, 0);

        // Spurious kernel output in RUN with no credit, plus a start while busy
        @(posedge clk); #2;
        clear_stats(2, 1);
        num_words = 2;
        start = 1'b1;
        src_valid = 1'b0;
        snk_ready = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        force_spur = 1'b1;
        @(posedge clk); #2;
        force_spur = 1'b0;
        @(negedge clk); #1;
        chk("spur_k_ovalid_seen", k_ovalid, 1);
        chk("spur_snk_valid", snk_valid, 0);
        chk("spur_k_oready", k_oready, 1);
        chk("spur_err_not_yet", err, 0);
        @(posedge clk); #2;
        num_words = 1;
        start = 1'b1;
        @(negedge clk); #1;
        chk("spur_err_set", err, 1);
        chk("spur_busy", busy, 1);
        @(posedge clk); #2;
        start = 1'b0;
        src_valid = 1'b1;
        wait_done("spur");
        src_valid = 1'b0;
        $display("[TB] job spur n=2 in=%0d out=%0d err=%0d", in_beats, out_beats, err);
        chk("spur_in_beats", in_beats, 2);
        chk("spur_out_beats", out_beats, 2);
        chk("spur_done_pulses", done_pulses, 1);
        chk("spur_err_sticky", err, 1);
        v = '{n:2, lat:1, stall:0, exp_in:2, exp_out:2, exp_stall_in:0, exp_err:0};
        run_job(v, "after_spur");

        // Asynchronous reset in the middle of a 16-word job
        @(posedge clk); #2;
        clear_stats(16, 3);
        num_words = 16;
        start = 1'b1;
        src_valid = 1'b1;
        snk_ready = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int c = 0; c < 100 && in_beats < 5; c++) begin
            @(negedge clk); #1;
        end
        chk("midrst_reached_5", in_beats, 5);
        #1;
        rst = 1'b1;
        #1;
        $display("[TB] job midrst n=16 reset after in=%0d", in_beats);
        chk("midrst_busy", busy, 0);
        chk("midrst_src_ready", src_ready, 0);
        chk("midrst_k_ivalid", k_ivalid, 0);
        chk("midrst_k_oready", k_oready, 0);
        chk("midrst_snk_valid", snk_valid, 0);
        chk("midrst_done", done, 0);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        src_valid = 1'b0;
        v = '{n:3, lat:2, stall:0, exp_in:3, exp_out:3, exp_stall_in:0, exp_err:0};
        run_job(v, "after_rst");

`ifdef MAIN_STREAM_CTRL_PERF_CNT_EN
        v = '{n:4, lat:2, stall:0, exp_in:4, exp_out:4, exp_stall_in:0, exp_err:0};
        run_job(v, "perf");
        chk("perf_cycle_count_at_done", cc_at_done, 7);
        repeat (3) @(posedge clk);
        #2;
        chk("perf_cycle_count_held", cycle_count, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/main_stream_ctrl.md
Name: main_stream_ctrl

Overview:
- Launch/sequencing controller for the vectorised kernel top. The kernel top is a bank of identical kernel lanes sharing one ivalid/iready/ovalid/oready handshake.
- Accepts a start command with a word count, gates the upstream stream into the kernel, and limits in-flight words with credits.
- Counts accepted input and output beats, and pulses done once the last result word leaves.
- Sits between the host/shell stream interface and the kernel top instance.

Parameters:
- CNTW, 32, width of the word-count and beat counters.
- MAX_INFLIGHT, 16, maximum words accepted by the kernel but not yet emitted. Range 1..255.
- CRW, 8, credit counter width; must satisfy 2^CRW > MAX_INFLIGHT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  launch pulse; sampled only in IDLE.
- num_words  in  CNTW  words to process; captured on accepted start.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky spurious-output flag; cleared by the next accepted start.
- src_valid  in  1  upstream word valid.
- src_ready  out  1  upstream ready.
- k_ivalid  out  1  to kernel ivalid.
- k_iready  in  1  from kernel iready.
- k_ovalid  in  1  from kernel ovalid.
- k_oready  out  1  to kernel oready.
- snk_valid  out  1  downstream result valid.
- snk_ready  in  1  downstream ready.
- cycle_count  out  32  launch-to-done cycles (optional feature).

Behaviour:
- Reset: state=IDLE; all counters=0; err=0.
  - Outputs busy, done, src_ready, k_ivalid, k_oready, snk_valid are 0 while in reset and in IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE. The state register is updated on posedge clk.
- IDLE -> RUN: on start=1. Captures num_words into tgt, clears in_cnt, out_cnt and credit, clears err.
  - If num_words=0, IDLE -> DONE instead.
- Issue gating: issue_ok = (state==RUN) & (in_cnt<tgt) & (credit<MAX_INFLIGHT).
  - k_ivalid = src_valid & issue_ok.
  - src_ready = k_iready & issue_ok.
  - Input beat = src_valid & k_iready & issue_ok.
- Output path: out_ok = state in {RUN, DRAIN}.
  - snk_valid = k_ovalid & out_ok & (credit!=0).
  - k_oready = snk_ready & out_ok.
  - Output beat = k_ovalid & k_oready & (credit!=0).
- Combinational paths: the handshakes above are combinational through this block. The only state feeding them is registered.
- Counters:
  - in_cnt increments on each input beat.
  - out_cnt increments on each output beat.
  - credit: +1 on input beat only, -1 on output beat only, unchanged when both occur in the same cycle.
  - Credit never exceeds MAX_INFLIGHT. At credit==MAX_INFLIGHT, issue is blocked even if an output beat happens in the same cycle (no comb path from k_ovalid to k_ivalid).
- RUN -> DRAIN: when in_cnt reaches tgt (registered compare, the cycle after the last input beat).
- DRAIN -> DONE: the cycle after the output beat that makes out_cnt==tgt.
  - Also valid directly RUN -> DONE if both conditions hold at once.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start during DONE is ignored.
- Spurious kernel output: k_ovalid & k_oready & (credit==0) in RUN/DRAIN sets err. The beat is consumed, not counted and not forwarded (snk_valid=0).
- start while busy: ignored, no effect on counters.
- Async reset mid-operation: immediate return to IDLE. In-flight kernel data is abandoned; the kernel shares rst and flushes too.
- Counter arithmetic: unsigned CNTW bits with no wrap. in_cnt and out_cnt never exceed tgt.

Optional Feature:
- Macro: MAIN_STREAM_CTRL_PERF_CNT_EN.
- Defined: a 32-bit counter clears on accepted start and increments every cycle in RUN/DRAIN. cycle_count holds its value from done until the next start. The counter saturates at 0xFFFFFFFF.
- Undefined: cycle_count is tied to 0 and no counter is synthesised.

Decomposition:
- Package main_stream_ctrl_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3);
  - default CNTW and MAX_INFLIGHT localparams;
  - CRW derivation function.
- Sub-module main_ctrl_credit_cnt: up/down saturating credit counter with inc, dec and limit inputs, and full/empty outputs. It is instantiated once.

Test Plan:
- num_words=8, src_valid=1, k_iready=1, kernel latency 3, snk_ready=1:
  - exactly 8 input beats and 8 output beats;
  - done pulses once, on the cycle after the 8th output beat;
  - busy is 0 afterwards.
- num_words=0: done pulses 1 cycle after start; no k_ivalid at any time; busy stays 0.
- MAX_INFLIGHT=4, num_words=10, snk_ready=0 for 20 cycles:
  - exactly 4 input beats, then src_ready=0;
  - after snk_ready=1, all 10 complete and credit never exceeds 4.
- Kernel asserts k_ovalid with credit==0 in RUN: err=1, snk_valid=0, and err stays set until the next start.
- rst asserted mid-RUN after 5 of 16 beats: all outputs go to 0 immediately; after release, a new start with num_words=3 completes normally.
- With MAIN_STREAM_CTRL_PERF_CNT_EN, num_words=4, one input beat per cycle, latency 2: cycle_count=7 at done, held after done.
